alu_core_seq: RTL

Parametrised, clocked successor to the combinational-stimulus ALU. It accepts one packed instruction per handshake and reads operands from an internal register file. It executes in a fixed 4-state sequence, writes the result back, and reports the result and signed overflow. It sits between the instruction source (testbench or future fetch unit) and the rest of the datapath. Register count, data width and immediate width are generic.

---
 rtl/alu_core_seq.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/alu_core_seq.sv
// Sequential ALU core: accepts one packed instruction per handshake, reads operands
// from an internal register file, executes in a fixed IDLE/READ/EXEC/WB sequence.
module alu_core_seq #(
    parameter int DATA_W = 16,
    parameter int REG_AW = 3,
    parameter int IMM_W  = 16,
    localparam int INST_W = 4 + 3*REG_AW + IMM_W
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [INST_W-1:0] INST,
    input  logic              INST_VALID,
    output logic              INST_READY,
    output logic [DATA_W-1:0] D_out,
    output logic              Over_Flow,
    output logic              OVF_STICKY,
    output logic              Done
);
    localparam int NREG = 2**REG_AW;
    localparam int SH_W = $clog2(DATA_W);
    localparam int MSB  = DATA_W - 1;

    localparam logic [3:0] OP_ADD  = 4'b0001;
    localparam logic [3:0] OP_ADDI = 4'b0010;
    localparam logic [3:0] OP_SUB  = 4'b0011;
    localparam logic [3:0] OP_AND  = 4'b0100;
    localparam logic [3:0] OP_OR   = 4'b0101;
    localparam logic [3:0] OP_XOR  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1000;
    localparam logic [3:0] OP_SRL  = 4'b1001;

    typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;

    state_t              state_q, state_d;
    logic [INST_W-1:0]   inst_q, inst_d;
    logic [DATA_W-1:0]   a_q, a_d, b_q, b_d, res_q, res_d, dout_q, dout_d;
    logic                ovf_q, ovf_d, wr_q, wr_d;
    logic                ovf_out_q, ovf_out_d, sticky_q, sticky_d, done_q, done_d;
    logic [DATA_W-1:0]   regs_q [NREG];
    logic [DATA_W-1:0]   regs_d [NREG];

    logic [3:0]          opc;
    logic [REG_AW-1:0]   rd, rs, rt;
    logic [IMM_W-1:0]    imm;
    logic [DATA_W-1:0]   imm_ext, sum, diff;

    assign opc     = inst_q[INST_W-1 -: 4];
    assign rd      = inst_q[INST_W-5 -: REG_AW];
    assign rs      = inst_q[INST_W-5-REG_AW -: REG_AW];
    assign rt      = inst_q[INST_W-5-2*REG_AW -: REG_AW];
    assign imm     = inst_q[IMM_W-1:0];
    assign imm_ext = DATA_W'($signed(imm));
    assign sum     = a_q + b_q;
    assign diff    = a_q - b_q;

    always_comb begin
        state_d   = state_q;
        inst_d    = inst_q;
        a_d       = a_q;
        b_d       = b_q;
        res_d     = res_q;
        ovf_d     = ovf_q;
        wr_d      = wr_q;
        dout_d    = dout_q;
        ovf_out_d = ovf_out_q;
        sticky_d  = sticky_q;
        done_d    = 1'b0;
        regs_d    = regs_q;
        case (state_q)
            IDLE: begin
                if (INST_VALID) begin
                    inst_d  = INST;
                    state_d = READ;
                end
            end
            READ: begin
                // R0 is never written, so indexing it always yields zero.
                a_d     = regs_q[rs];
                b_d     = (opc == OP_ADDI) ? imm_ext : regs_q[rt];
                state_d = EXEC;
            end
            EXEC: begin
                res_d = res_q;
                ovf_d = 1'b0;
                wr_d  = 1'b1;
                case (opc)
                    OP_ADD, OP_ADDI: begin
                        res_d = sum;
                        ovf_d = (a_q[MSB] == b_q[MSB]) && (sum[MSB] != a_q[MSB]);
                    end
                    OP_SUB: begin
                        res_d = diff;
                        ovf_d = (a_q[MSB] != b_q[MSB]) && (diff[MSB] != a_q[MSB]);
                    end
                    OP_AND:  res_d = a_q & b_q;
                    OP_OR:   res_d = a_q | b_q;
                    OP_XOR:  res_d = a_q ^ b_q;
                    OP_SLT:  res_d = {{(DATA_W-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
                    OP_SLL:  res_d = a_q << b_q[SH_W-1:0];
                    OP_SRL:  res_d = a_q >> b_q[SH_W-1:0];
                    default: wr_d  = 1'b0;
                endcase
                state_d = WB;
            end
            WB: begin
                if (wr_q) begin
                    dout_d = res_q;
                    if (rd != '0) regs_d[rd] = res_q;
                end
                ovf_out_d = ovf_q;
                sticky_d  = sticky_q | ovf_q;
                done_d    = 1'b1;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q   <= IDLE;
            inst_q    <= '0;
            a_q       <= '0;
            b_q       <= '0;
            res_q     <= '0;
            ovf_q     <= 1'b0;
            wr_q      <= 1'b0;
            dout_q    <= '0;
            ovf_out_q <= 1'b0;
            sticky_q  <= 1'b0;
            done_q    <= 1'b0;
            for (int i = 0; i < NREG; i++) regs_q[i] <= '0;
        end else begin
            state_q   <= state_d;
            inst_q    <= inst_d;
            a_q       <= a_d;
            b_q       <= b_d;
            res_q     <= res_d;
            ovf_q     <= ovf_d;
            wr_q      <= wr_d;
            dout_q    <= dout_d;
            ovf_out_q <= ovf_out_d;
            sticky_q  <= sticky_d;
            done_q    <= done_d;
            for (int i = 0; i < NREG; i++) regs_q[i] <= regs_d[i];
        end
    end

    assign INST_READY = (state_q == IDLE);
    assign D_out      = dout_q;
    assign Over_Flow  = ovf_out_q;
    assign OVF_STICKY = sticky_q;
    assign Done       = done_q;
endmodule
